// File: rtl/fence_t_sequencer_pkg.sv
// fence_t_sequencer_pkg
// Shared types and constants for the fence.t sequencer.
//   fence_t_state_e     : sequencer FSM state encoding
//   FENCE_T_CH_*        : flush channel indices (bit positions in the channel mask)
//   VLEN_DEFAULT        : default address width
package fence_t_sequencer_pkg;

   localparam int unsigned VLEN_DEFAULT = 64;

   localparam int unsigned FENCE_T_CH_DCACHE = 0;
   localparam int unsigned FENCE_T_CH_ICACHE = 1;
   localparam int unsigned FENCE_T_CH_TLB    = 2;
   localparam int unsigned FENCE_T_CH_BP     = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLUSH     = 2'd1,
      RST_UARCH = 2'd2,
      PAD       = 2'd3
   } fence_t_state_e;

endpackage

// File: rtl/fence_t_sequencer_if.sv
// fence_t_sequencer_if
// Bundles the request, flush handshake and result signals of the fence.t
// sequencer. Signal names carry the sequencer's own i/o direction.
//   master : flush controller / cache side (drives requests and acks)
//   slave  : the sequencer itself
interface fence_t_sequencer_if
   import fence_t_sequencer_pkg::*;
#(
   parameter int unsigned VLEN      = VLEN_DEFAULT,
   parameter int unsigned NrFlushCh = 4,
   parameter int unsigned PadW      = 10
);
   logic                 fence_t_valid_i;
   logic [NrFlushCh-1:0] fence_t_ch_mask_i;
   logic [PadW-1:0]      fence_t_pad_i;
   logic [VLEN-1:0]      pc_commit_i;
   logic [VLEN-1:0]      boot_addr_i;
   logic [NrFlushCh-1:0] flush_req_o;
   logic [NrFlushCh-1:0] flush_ack_i;
   logic                 rst_uarch_no;
   logic [VLEN-1:0]      rst_addr_o;
   logic                 halt_o;
   logic                 done_o;
   logic [PadW-1:0]      last_cycles_o;

   modport master (
      output fence_t_valid_i, fence_t_ch_mask_i, fence_t_pad_i, pc_commit_i,
             boot_addr_i, flush_ack_i,
      input  flush_req_o, rst_uarch_no, rst_addr_o, halt_o, done_o, last_cycles_o
   );

   modport slave (
      input  fence_t_valid_i, fence_t_ch_mask_i, fence_t_pad_i, pc_commit_i,
             boot_addr_i, flush_ack_i,
      output flush_req_o, rst_uarch_no, rst_addr_o, halt_o, done_o, last_cycles_o
   );

endinterface

// File: rtl/fence_t_sequencer_flush_req_tracker.sv
// fence_t_sequencer_flush_req_tracker
// Single flush channel: a pending bit set when a fence.t selecting this
// channel is accepted and cleared by the channel's ack. The pending bit is
// the channel's flush request.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_set         : fence accepted with this channel selected
//   i_ack         : flush done from the state holder
//   o_req         : flush request (registered)
module fence_t_sequencer_flush_req_tracker (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_set,
   input  logic i_ack,
   output logic o_req
);

   logic r_pending;

   // Set only happens in IDLE, where the bit is already clear, so set/ack
   // never compete for a live request. Acks with nothing pending are no-ops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pending <= 1'b0;
      end else if (i_set) begin
         r_pending <= 1'b1;
      end else if (i_ack) begin
         r_pending <= 1'b0;
      end
   end

   assign o_req = r_pending;

endmodule

// File: rtl/fence_t_sequencer.sv
// fence_t_sequencer
// Sequences a fence.t: flush the selected state holders over per-channel
// req/ack, hold the uarch reset for RstCycles cycles, then pad the whole
// operation to a programmable minimum so latency is content-independent.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : fence request, flush req/ack, uarch reset, resume
//                   address, halt, done pulse and last elapsed count
module fence_t_sequencer
   import fence_t_sequencer_pkg::*;
#(
   parameter int unsigned VLEN      = VLEN_DEFAULT,
   parameter int unsigned NrFlushCh = 4,
   parameter int unsigned RstCycles = 16,
   parameter int unsigned PadW      = 10
) (
   input logic                clk_i,
   input logic                rst_ni,
   fence_t_sequencer_if.slave bus
);

   localparam int unsigned CntW = $clog2(RstCycles + 1);

   fence_t_state_e       r_state;
   logic [PadW-1:0]      r_elapsed;
   logic [PadW-1:0]      r_pad;
   logic [PadW-1:0]      r_last_cycles;
   logic [CntW-1:0]      r_rst_cnt;
   logic [VLEN-1:0]      r_rst_addr;
   logic                 r_halt;
   logic                 r_done;
   logic                 r_rst_uarch_n;

   logic [NrFlushCh-1:0] w_pending;
   logic                 w_accept;
   logic                 w_flush_clear;
   logic [PadW-1:0]      w_elapsed_inc;

   assign w_accept      = (r_state == IDLE) && bus.fence_t_valid_i;
   // Every outstanding channel is either already clear or acking right now.
   assign w_flush_clear = ((w_pending & ~bus.flush_ack_i) == '0);
   // Saturate so a pad target of all-ones is still reachable.
   assign w_elapsed_inc = (&r_elapsed) ? r_elapsed : r_elapsed + PadW'(1);

   for (genvar gi = 0; gi < NrFlushCh; gi++) begin : g_ch
      fence_t_sequencer_flush_req_tracker u_tracker (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .i_set (w_accept & bus.fence_t_ch_mask_i[gi]),
         .i_ack (bus.flush_ack_i[gi]),
         .o_req (w_pending[gi])
      );
   end

   // r_done is computed one cycle ahead: it is high exactly in the PAD cycle
   // where elapsed >= pad, which is the final busy cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= IDLE;
         r_elapsed     <= '0;
         r_pad         <= '0;
         r_last_cycles <= '0;
         r_rst_cnt     <= '0;
         r_rst_addr    <= bus.boot_addr_i;
         r_halt        <= 1'b0;
         r_done        <= 1'b0;
         r_rst_uarch_n <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.fence_t_valid_i) begin
                  r_state    <= FLUSH;
                  r_pad      <= bus.fence_t_pad_i;
                  r_rst_addr <= bus.pc_commit_i + VLEN'(4);
                  r_elapsed  <= '0;
                  r_halt     <= 1'b1;
               end
            end
            FLUSH: begin
               r_elapsed <= w_elapsed_inc;
               if (w_flush_clear) begin
                  r_state       <= RST_UARCH;
                  r_rst_cnt     <= '0;
                  r_rst_uarch_n <= 1'b0;
               end
            end
            RST_UARCH: begin
               r_elapsed <= w_elapsed_inc;
               if (r_rst_cnt == CntW'(RstCycles - 1)) begin
                  r_state       <= PAD;
                  r_rst_uarch_n <= 1'b1;
                  r_done        <= (w_elapsed_inc >= r_pad);
               end else begin
                  r_rst_cnt <= r_rst_cnt + CntW'(1);
               end
            end
            PAD: begin
               r_elapsed <= w_elapsed_inc;
               if (r_done) begin
                  r_state       <= IDLE;
                  r_halt        <= 1'b0;
                  r_done        <= 1'b0;
                  r_last_cycles <= r_elapsed;
               end else begin
                  r_done <= (w_elapsed_inc >= r_pad);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.flush_req_o   = w_pending;
   assign bus.rst_uarch_no  = r_rst_uarch_n;
   assign bus.rst_addr_o    = r_rst_addr;
   assign bus.halt_o        = r_halt;
   assign bus.done_o        = r_done;
   assign bus.last_cycles_o = r_last_cycles;

endmodule

// File: tb/tb_fence_t_sequencer.sv
module tb_fence_t_sequencer;
   import fence_t_sequencer_pkg::*;

   localparam int VLEN  = 64;
   localparam int NCH   = 4;
   localparam int RST   = 16;
   localparam int PADW  = 10;
   localparam int LIMIT = 1200;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   fence_t_sequencer_if #(.VLEN(VLEN), .NrFlushCh(NCH), .PadW(PADW)) bus ();

   fence_t_sequencer #(
      .VLEN(VLEN), .NrFlushCh(NCH), .RstCycles(RST), .PadW(PADW)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // observations of the last run_fence
   int          obs_done_cnt, obs_done_k, obs_halt_first, obs_halt_last;
   int          obs_rst_cnt, obs_rst_first, obs_end_k, obs_last;
   int          obs_req_cnt [NCH];
   int          obs_req_first [NCH];
   logic [63:0] obs_addr1;
   bit          obs_timeout;

   // Flush phase length: the latest ack among selected channels, at least 1.
   function automatic int model_flush(input logic [3:0] mask, input int d [NCH]);
      int f = 1;
      for (int c = 0; c < NCH; c++)
         if (mask[c] && d[c] > f) f = d[c];
      return f;
   endfunction

   function automatic int model_busy(input int f, input int pad);
      return (f + RST + 1 > pad + 1) ? f + RST + 1 : pad + 1;
   endfunction

   // Issue one fence at cycle T; cycle k is T+k. Ack of channel c is pulsed
   // in cycle T+d[c]. Runs until halt falls (bounded by LIMIT).
   task automatic run_fence(input logic [3:0] mask, input int pad, input logic [63:0] pc,
                            input int d [NCH], input bit noise, input bit resend);
      @(negedge clk_i);
      bus.fence_t_valid_i   = 1'b1;
      bus.fence_t_ch_mask_i = mask;
      bus.fence_t_pad_i     = PADW'(pad);
      bus.pc_commit_i       = pc;
      bus.flush_ack_i       = '0;
      obs_done_cnt = 0; obs_done_k = 0; obs_halt_first = 0; obs_halt_last = 0;
      obs_rst_cnt = 0; obs_rst_first = 0; obs_end_k = 0; obs_last = -1;
      obs_addr1 = '0; obs_timeout = 1'b0;
      for (int c = 0; c < NCH; c++) begin obs_req_cnt[c] = 0; obs_req_first[c] = 0; end
      for (int k = 1; k <= LIMIT; k++) begin
         @(negedge clk_i);
         if (bus.halt_o) begin
            if (obs_halt_first == 0) obs_halt_first = k;
            obs_halt_last = k;
         end
         if (bus.done_o) begin obs_done_cnt++; obs_done_k = k; end
         if (!bus.rst_uarch_no) begin
            if (obs_rst_first == 0) obs_rst_first = k;
            obs_rst_cnt++;
         end
         for (int c = 0; c < NCH; c++)
            if (bus.flush_req_o[c]) begin
               if (obs_req_first[c] == 0) obs_req_first[c] = k;
               obs_req_cnt[c]++;
            end
         if (k == 1) obs_addr1 = bus.rst_addr_o;
         if (k > 1 && !bus.halt_o && obs_halt_first != 0) begin
            obs_end_k = k;
            obs_last  = int'(bus.last_cycles_o);
            break;
         end
         // the request inputs are scrambled after acceptance; they must be latched
         bus.fence_t_ch_mask_i = 4'($urandom);
         bus.fence_t_pad_i     = PADW'($urandom);
         bus.pc_commit_i       = {$urandom, $urandom};
         bus.fence_t_valid_i   = resend && !bus.rst_uarch_no;
         bus.flush_ack_i       = '0;
         for (int c = 0; c < NCH; c++)
            if (mask[c] && d[c] == k) bus.flush_ack_i[c] = 1'b1;
         if (noise) bus.flush_ack_i = bus.flush_ack_i | (4'($urandom) & ~mask);
      end
      bus.flush_ack_i     = '0;
      bus.fence_t_valid_i = 1'b0;
      if (obs_end_k == 0) obs_timeout = 1'b1;
      $display("fence mask=%b pad=%0d pc=%h done_at=%0d last=%0d rst_low=%0d",
               mask, pad, pc, obs_done_k, obs_last, obs_rst_cnt);
   endtask

   task automatic test_reset();
      bus.boot_addr_i = {32'h0, $urandom};
      rst_ni = 1'b1;
      #2 rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      total++; if (bus.flush_req_o !== 4'b0) begin bad++; $display("FAIL reset_req: got %b want 0000", bus.flush_req_o); end
      total++; if (bus.rst_uarch_no !== 1'b1) begin bad++; $display("FAIL reset_rst_uarch: got %b want 1", bus.rst_uarch_no); end
      total++; if (bus.rst_addr_o !== bus.boot_addr_i) begin bad++; $display("FAIL reset_addr: got %h want %h", bus.rst_addr_o, bus.boot_addr_i); end
      total++; if (bus.halt_o !== 1'b0 || bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_halt_done: got %b%b want 00", bus.halt_o, bus.done_o); end
      total++; if (bus.last_cycles_o !== '0) begin bad++; $display("FAIL reset_last: got %0d want 0", bus.last_cycles_o); end
      @(negedge clk_i) rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_masked_flush();
      int d [NCH];
      logic [3:0] mask;
      int f, busy;
      mask = 4'((1 << FENCE_T_CH_DCACHE) | (1 << FENCE_T_CH_TLB));
      d[0] = 3; d[1] = 0; d[2] = 5; d[3] = 0;
      run_fence(mask, 100, 64'h1000, d, 1'b0, 1'b0);
      f = model_flush(mask, d);
      busy = model_busy(f, 100);
      total++; if (obs_timeout) begin bad++; $display("FAIL mf_timeout: halt high after %0d cycles want fall", LIMIT); end
      total++; if (obs_done_k !== busy || obs_done_cnt !== 1) begin bad++; $display("FAIL mf_done: got at %0d x%0d want at %0d x1", obs_done_k, obs_done_cnt, busy); end
      total++; if (obs_halt_first !== 1 || obs_halt_last !== busy) begin bad++; $display("FAIL mf_halt: got %0d..%0d want 1..%0d", obs_halt_first, obs_halt_last, busy); end
      total++; if (obs_rst_first !== f + 1 || obs_rst_cnt !== RST) begin bad++; $display("FAIL mf_rst: got from %0d for %0d want from %0d for %0d", obs_rst_first, obs_rst_cnt, f + 1, RST); end
      total++; if (obs_req_cnt[0] !== 3 || obs_req_cnt[2] !== 5 || obs_req_cnt[1] !== 0 || obs_req_cnt[3] !== 0)
         begin bad++; $display("FAIL mf_req: got %0d %0d %0d %0d want 3 0 5 0", obs_req_cnt[0], obs_req_cnt[1], obs_req_cnt[2], obs_req_cnt[3]); end
      total++; if (obs_last !== 100) begin bad++; $display("FAIL mf_last: got %0d want 100", obs_last); end
   endtask

   task automatic test_zero_mask();
      int d [NCH];
      for (int c = 0; c < NCH; c++) d[c] = 1;
      run_fence(4'b0000, 0, 64'h2000, d, 1'b1, 1'b0);
      total++; if (obs_done_k !== 18 || obs_done_cnt !== 1) begin bad++; $display("FAIL zm_done: got at %0d x%0d want at 18 x1", obs_done_k, obs_done_cnt); end
      total++; if (obs_last !== 17) begin bad++; $display("FAIL zm_last: got %0d want 17", obs_last); end
      total++; if (obs_req_cnt[0] + obs_req_cnt[1] + obs_req_cnt[2] + obs_req_cnt[3] !== 0)
         begin bad++; $display("FAIL zm_req: got %0d req cycles want 0", obs_req_cnt[0] + obs_req_cnt[1] + obs_req_cnt[2] + obs_req_cnt[3]); end
      total++; if (obs_rst_first !== 2 || obs_rst_cnt !== RST) begin bad++; $display("FAIL zm_rst: got from %0d for %0d want from 2 for %0d", obs_rst_first, obs_rst_cnt, RST); end
   endtask

   task automatic test_resume_addr();
      int d [NCH];
      logic [63:0] pc, exp_addr, boot;
      for (int c = 0; c < NCH; c++) d[c] = 2;
      run_fence(4'b0010, 0, 64'h8000_0ffc, d, 1'b0, 1'b0);
      total++; if (obs_addr1 !== 64'h8000_1000) begin bad++; $display("FAIL ra_addr: got %h want 8000_1000", obs_addr1); end
      total++; if (bus.rst_addr_o !== 64'h8000_1000) begin bad++; $display("FAIL ra_hold: got %h want 8000_1000", bus.rst_addr_o); end
      pc = 64'hffff_ffff_ffff_fffe;
      exp_addr = pc + 64'd4;
      run_fence(4'b0000, 0, pc, d, 1'b0, 1'b0);
      total++; if (obs_addr1 !== exp_addr) begin bad++; $display("FAIL ra_wrap: got %h want %h", obs_addr1, exp_addr); end
      boot = {$urandom, $urandom};
      @(negedge clk_i);
      bus.boot_addr_i = boot;
      rst_ni = 1'b0;
      #1;
      total++; if (bus.rst_addr_o !== boot) begin bad++; $display("FAIL ra_boot: got %h want %h", bus.rst_addr_o, boot); end
      @(negedge clk_i) rst_ni = 1'b1;
   endtask

   task automatic test_ignored_inputs();
      int d [NCH];
      int busy, extra_halt;
      d[0] = 3; d[1] = 2; d[2] = 6; d[3] = 4;
      run_fence(4'b0101, 30, 64'h3000, d, 1'b1, 1'b1);
      busy = model_busy(model_flush(4'b0101, d), 30);
      total++; if (obs_done_k !== busy || obs_done_cnt !== 1) begin bad++; $display("FAIL ig_done: got at %0d x%0d want at %0d x1", obs_done_k, obs_done_cnt, busy); end
      total++; if (obs_req_cnt[1] !== 0 || obs_req_cnt[3] !== 0) begin bad++; $display("FAIL ig_unsel_req: got %0d %0d want 0 0", obs_req_cnt[1], obs_req_cnt[3]); end
      total++; if (obs_req_cnt[2] !== 6) begin bad++; $display("FAIL ig_req2: got %0d want 6", obs_req_cnt[2]); end
      extra_halt = 0;
      repeat (4) begin @(negedge clk_i); if (bus.halt_o) extra_halt++; end
      total++; if (extra_halt !== 0) begin bad++; $display("FAIL ig_no_queue: got %0d halt cycles want 0", extra_halt); end
   endtask

   task automatic test_timing_independence();
      int d [NCH];
      for (int c = 0; c < NCH; c++) d[c] = 1;
      run_fence(4'b0111, 200, 64'h4000, d, 1'b0, 1'b0);
      total++; if (obs_done_k !== 201 || obs_last !== 200) begin bad++; $display("FAIL ti_fast: got done %0d last %0d want 201 200", obs_done_k, obs_last); end
      for (int c = 0; c < NCH; c++) d[c] = 40;
      run_fence(4'b0111, 200, 64'h4000, d, 1'b0, 1'b0);
      total++; if (obs_done_k !== 201 || obs_last !== 200) begin bad++; $display("FAIL ti_slow: got done %0d last %0d want 201 200", obs_done_k, obs_last); end
      total++; if (obs_req_cnt[0] !== 40) begin bad++; $display("FAIL ti_req: got %0d want 40", obs_req_cnt[0]); end
   endtask

   task automatic test_back_to_back();
      int dones [$];
      int halt_low;
      halt_low = 0;
      @(negedge clk_i);
      bus.fence_t_valid_i   = 1'b1;
      bus.fence_t_ch_mask_i = 4'b0000;
      bus.fence_t_pad_i     = '0;
      bus.flush_ack_i       = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_i);
         if (bus.done_o) dones.push_back(k);
         if (!bus.halt_o) halt_low++;
         if (k == 37) bus.fence_t_valid_i = 1'b0;
      end
      $display("back_to_back dones=%0d halt_low=%0d", dones.size(), halt_low);
      total++; if (dones.size() !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", dones.size()); end
      total++; if ((dones.size() > 0 ? dones[0] : -1) !== 18) begin bad++; $display("FAIL b2b_first: got %0d want 18", dones.size() > 0 ? dones[0] : -1); end
      total++; if ((dones.size() > 1 ? dones[1] : -1) !== 37) begin bad++; $display("FAIL b2b_second: got %0d want 37", dones.size() > 1 ? dones[1] : -1); end
      total++; if (halt_low !== 4) begin bad++; $display("FAIL b2b_halt_low: got %0d want 4", halt_low); end
   endtask

   task automatic test_mid_reset();
      int d [NCH];
      int low, k;
      // reset during RST_UARCH
      @(negedge clk_i);
      bus.fence_t_valid_i = 1'b1; bus.fence_t_ch_mask_i = 4'b0011; bus.fence_t_pad_i = PADW'(50);
      bus.pc_commit_i = 64'h5000; bus.flush_ack_i = '0;
      low = 0; k = 0;
      while (low < 5 && k < 40) begin
         @(negedge clk_i);
         k++;
         bus.fence_t_valid_i = 1'b0;
         if (!bus.rst_uarch_no) low++;
         bus.flush_ack_i = (k == 2) ? 4'b0011 : 4'b0000;
      end
      total++; if (low !== 5) begin bad++; $display("FAIL mr_reach: got %0d low cycles want 5", low); end
      rst_ni = 1'b0;
      #1;
      total++; if (bus.rst_uarch_no !== 1'b1 || bus.halt_o !== 1'b0 || bus.flush_req_o !== 4'b0)
         begin bad++; $display("FAIL mr_rst: got rst=%b halt=%b req=%b want 1 0 0000", bus.rst_uarch_no, bus.halt_o, bus.flush_req_o); end
      @(negedge clk_i) rst_ni = 1'b1;
      bus.flush_ack_i = '0;
      // reset during FLUSH with requests outstanding
      @(negedge clk_i);
      bus.fence_t_valid_i = 1'b1; bus.fence_t_ch_mask_i = 4'b1111;
      repeat (3) begin @(negedge clk_i); bus.fence_t_valid_i = 1'b0; end
      total++; if (bus.flush_req_o !== 4'b1111) begin bad++; $display("FAIL mr_req_up: got %b want 1111", bus.flush_req_o); end
      rst_ni = 1'b0;
      #1;
      total++; if (bus.flush_req_o !== 4'b0 || bus.halt_o !== 1'b0) begin bad++; $display("FAIL mr_req_drop: got req=%b halt=%b want 0000 0", bus.flush_req_o, bus.halt_o); end
      @(negedge clk_i) rst_ni = 1'b1;
      d[0] = 2; d[1] = 0; d[2] = 4; d[3] = 0;
      run_fence(4'b0101, 10, 64'h6000, d, 1'b0, 1'b0);
      total++; if (obs_done_k !== 21 || obs_done_cnt !== 1 || obs_last !== 20)
         begin bad++; $display("FAIL mr_after: got done %0d x%0d last %0d want 21 x1 20", obs_done_k, obs_done_cnt, obs_last); end
   endtask

   task automatic test_random();
      int d [NCH];
      logic [3:0]  mask;
      logic [63:0] pc;
      int pad, f, busy;
      for (int n = 0; n < 12; n++) begin
         mask = 4'($urandom);
         pad  = int'($urandom_range(0, 120));
         pc   = {$urandom, $urandom};
         for (int c = 0; c < NCH; c++) d[c] = int'($urandom_range(1, 30));
         run_fence(mask, pad, pc, d, 1'($urandom), 1'($urandom));
         f = model_flush(mask, d);
         busy = model_busy(f, pad);
         total++; if (obs_timeout || obs_done_k !== busy || obs_done_cnt !== 1)
            begin bad++; $display("FAIL rnd_done[%0d]: got at %0d x%0d want at %0d x1", n, obs_done_k, obs_done_cnt, busy); end
         total++; if (obs_halt_first !== 1 || obs_halt_last !== busy)
            begin bad++; $display("FAIL rnd_halt[%0d]: got %0d..%0d want 1..%0d", n, obs_halt_first, obs_halt_last, busy); end
         total++; if (obs_rst_first !== f + 1 || obs_rst_cnt !== RST)
            begin bad++; $display("FAIL rnd_rst[%0d]: got from %0d for %0d want from %0d for %0d", n, obs_rst_first, obs_rst_cnt, f + 1, RST); end
         for (int c = 0; c < NCH; c++) begin
            total++; if (obs_req_cnt[c] !== (mask[c] ? d[c] : 0) || obs_req_first[c] !== (mask[c] ? 1 : 0))
               begin bad++; $display("FAIL rnd_req[%0d] ch%0d: got %0d from %0d want %0d", n, c, obs_req_cnt[c], obs_req_first[c], mask[c] ? d[c] : 0); end
         end
         total++; if (obs_addr1 !== pc + 64'd4) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, obs_addr1, pc + 64'd4); end
         total++; if (obs_last !== busy - 1) begin bad++; $display("FAIL rnd_last[%0d]: got %0d want %0d", n, obs_last, busy - 1); end
      end
   endtask

   initial begin
      bus.fence_t_valid_i   = 1'b0;
      bus.fence_t_ch_mask_i = '0;
      bus.fence_t_pad_i     = '0;
      bus.pc_commit_i       = '0;
      bus.boot_addr_i       = '0;
      bus.flush_ack_i       = '0;
      rst_ni                = 1'b1;
      test_reset();
      test_masked_flush();
      test_zero_mask();
      test_resume_addr();
      test_ignored_inputs();
      test_timing_independence();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
